// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the sequenced binary-to-2^N decoder: mode encodings
// and FSM state encodings.
// -----------------------------------------------------------------------------
package decoder_pkg;

  // Transaction modes offered on the mode input
  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_SCAN  = 2'b10
  } state_e;

endpackage : decoder_pkg

// File: rtl/decoder_pattern.sv
// -----------------------------------------------------------------------------
// decoder_pattern
// Combinational index-to-pattern decoder.
//   i_index      : IN_W   binary index
//   i_therm_sel  : 1      1 = thermometer (bits [index:0] set), 0 = one-hot
//   o_pattern_c  : 2**IN_W decoded pattern (combinational)
// -----------------------------------------------------------------------------
module decoder_pattern #(
  parameter int unsigned IN_W = 3
) (
  input  logic [IN_W-1:0]      i_index,
  input  logic                 i_therm_sel,
  output logic [2**IN_W-1:0]   o_pattern_c
);

  localparam int unsigned OUT_W = 2**IN_W;

  // Per-bit compare avoids the shift overflow a (1<<(idx+1))-1 form has at OUT_W-1
  always_comb begin
    o_pattern_c = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (i_therm_sel) o_pattern_c[i] = (i <= 32'(i_index));
      else             o_pattern_c[i] = (i == 32'(i_index));
    end
  end

endmodule : decoder_pattern

// File: rtl/decoder_nto2n_seq.sv
// -----------------------------------------------------------------------------
// decoder_nto2n_seq
// Registered binary-to-2^N decoder fed over a valid/ready handshake. Each
// accepted code is driven for HOLD_CYCLES cycles (ONEHOT/THERM) or walked as a
// one-hot sweep from index 0 up to the code (SCAN), HOLD_CYCLES per step.
//   clk, rst   : clock, synchronous active-high reset
//   en         : global enable; low blanks out and freezes the sequencer
//   in_valid   : code/mode offered
//   in_ready   : combinational accept qualifier (IDLE & en & ~rst)
//   in, mode   : binary code and mode (00 onehot, 01 therm, 10 scan, 11 rsvd)
//   out        : registered decoded pattern
//   idx        : index currently driven
//   busy       : transaction in progress
//   done       : pulse on the final active cycle
//   err        : pulse with the first output of a reserved-mode transaction
// -----------------------------------------------------------------------------
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W        = 3,
  parameter int          HOLD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in,
  input  logic [1:0]           mode,
  output logic [2**IN_W-1:0]   out,
  output logic [IN_W-1:0]      idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned OUT_W = 2**IN_W;
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  if (HOLD_CYCLES < 1) begin : g_hold_chk
    $error("decoder_nto2n_seq: HOLD_CYCLES must be >= 1");
  end

  state_e             r_state;
  logic [IN_W-1:0]    r_code;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_cnt;
  logic [IN_W-1:0]    r_idx;
  logic [OUT_W-1:0]   r_out;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_frozen;

  logic               w_accept;
  logic               w_last_step;
  logic               w_step;
  logic [IN_W-1:0]    w_idx_inc;
  logic [IN_W-1:0]    w_pat_idx;
  logic               w_pat_therm;
  logic [OUT_W-1:0]   w_pat;

  assign in_ready = (r_state == ST_IDLE) & en & ~rst;
  assign w_accept = in_valid & in_ready;

  // Current step is the last one of the transaction (DRIVE has a single step)
  assign w_last_step = (r_state == ST_DRIVE) || (r_idx == r_code);
  assign w_idx_inc   = IN_W'(r_idx + 1'b1);

  // SCAN advances to the next index when the current step's hold expires
  assign w_step = (r_state == ST_SCAN) && en && !r_frozen &&
                  (r_cnt == '0) && (r_idx != r_code);

  // Pattern source: incoming code on accept, next sweep index, else current idx
  always_comb begin
    w_pat_idx   = r_idx;
    w_pat_therm = (r_mode == MODE_THERM);
    if (w_accept) begin
      w_pat_idx   = (mode == MODE_SCAN) ? '0 : in;
      w_pat_therm = (mode == MODE_THERM);
    end else if (w_step) begin
      w_pat_idx   = w_idx_inc;
    end
  end

  decoder_pattern #(
    .IN_W (IN_W)
  ) u_pattern (
    .i_index     (w_pat_idx),
    .i_therm_sel (w_pat_therm),
    .o_pattern_c (w_pat)
  );

  // Sequencer: handshake, hold counter, sweep index and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_code   <= '0;
      r_mode   <= MODE_ONEHOT;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_out    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_frozen <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state  <= (mode == MODE_SCAN) ? ST_SCAN : ST_DRIVE;
            r_code   <= in;
            r_mode   <= mode;
            r_idx    <= w_pat_idx;
            r_cnt    <= CNT_W'(HOLD_CYCLES - 1);
            r_out    <= w_pat;
            r_busy   <= 1'b1;
            r_frozen <= 1'b0;
            r_err    <= (mode == MODE_RSVD);
            r_done   <= (HOLD_CYCLES == 1) && ((mode != MODE_SCAN) || (in == '0));
          end
        end

        ST_DRIVE, ST_SCAN: begin
          if (!en) begin
            // Blank and freeze; the blanked cycle does not consume hold count
            r_out    <= '0;
            r_done   <= 1'b0;
            r_frozen <= 1'b1;
          end else if (r_frozen) begin
            // Restore the pattern; this cycle is the one lost to the freeze
            r_out    <= w_pat;
            r_frozen <= 1'b0;
            r_done   <= w_last_step && (r_cnt == '0);
          end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= w_last_step && (r_cnt == CNT_W'(1));
          end else if (w_step) begin
            r_idx  <= w_idx_inc;
            r_cnt  <= CNT_W'(HOLD_CYCLES - 1);
            r_out  <= w_pat;
            r_done <= (HOLD_CYCLES == 1) && (w_idx_inc == r_code);
          end else begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_out   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule : decoder_nto2n_seq

// File: tb/tb_decoder_nto2n_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_nto2n_seq
// Scoreboard bench for decoder_nto2n_seq (IN_W=3, HOLD_CYCLES=2). Stimulus
// pushes hand-computed per-cycle expectations; a monitor pops one entry per
// busy cycle and compares out/idx/done/err.
// -----------------------------------------------------------------------------
module tb_decoder_nto2n_seq;

  localparam int unsigned IN_W = 3;
  localparam int          HOLD = 2;

  typedef struct {
    logic [7:0] out;
    logic [2:0] idx;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [1:0] in_mode;
  logic [7:0] dout;
  logic [2:0] didx;
  logic       busy;
  logic       done;
  logic       err;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  decoder_nto2n_seq #(
    .IN_W        (IN_W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_code),
    .mode     (in_mode),
    .out      (dout),
    .idx      (didx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push(input logic [7:0] o, input logic [2:0] i,
                               input logic d, input logic e);
    exp_t x;
    x.out = o; x.idx = i; x.done = d; x.err = e;
    exp_q.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
    else n_pass++;
  endtask

  // Monitor: every busy cycle must match the next expected entry
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_busy: out=%h idx=%0d with empty scoreboard", dout, didx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout !== e.out || didx !== e.idx || done !== e.done || err !== e.err)
          $display("FAIL scoreboard: got out=%h idx=%0d done=%b err=%b, expected out=%h idx=%0d done=%b err=%b",
                   dout, didx, done, err, e.out, e.idx, e.done, e.err);
        else n_pass++;
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [1:0] m);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_code = c; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the transaction to end, then check the idle cycle after done
  task automatic finish_txn(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_out_zero"}, 32'(dout), 32'd0);
    chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_code = '0; in_mode = 2'b00;

    // Reset
    @(posedge clk); #1;
    chk("ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_busy_idx", {28'd0, busy, didx}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("ready_in_rst2", 32'(in_ready), 32'd0);
    rst = 1'b0; #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // ONEHOT 5
    push(8'h20, 3'd5, 1'b0, 1'b0);
    push(8'h20, 3'd5, 1'b1, 1'b0);
    send(3'd5, 2'b00);
    finish_txn("onehot5");

    // THERM 3, THERM 7, ONEHOT 0 back to back
    push(8'h0F, 3'd3, 1'b0, 1'b0);
    push(8'h0F, 3'd3, 1'b1, 1'b0);
    send(3'd3, 2'b01);
    finish_txn("therm3");
    push(8'hFF, 3'd7, 1'b0, 1'b0);
    push(8'hFF, 3'd7, 1'b1, 1'b0);
    send(3'd7, 2'b01);
    finish_txn("therm7");
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h01, 3'd0, 1'b1, 1'b0);
    send(3'd0, 2'b00);
    finish_txn("onehot0");

    // SCAN 2 with an ignored in_valid pulse mid-sweep
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h02, 3'd1, 1'b0, 1'b0);
    push(8'h02, 3'd1, 1'b0, 1'b0);
    push(8'h04, 3'd2, 1'b0, 1'b0);
    push(8'h04, 3'd2, 1'b1, 1'b0);
    send(3'd2, 2'b10);
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_code = 3'd7; in_mode = 2'b00;
    chk("ready_low_busy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_txn("scan2");

    // en low in IDLE: no acceptance
    en = 1'b0; #1;
    chk("ready_en_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_code = 3'd1; in_mode = 2'b00;
    @(posedge clk); #1;
    chk("no_accept_en_low", 32'(busy), 32'd0);
    in_valid = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    // SCAN 3 with en dropped for 3 cycles during the second cycle of idx 1
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h02, 3'd1, 1'b0, 1'b0);
    push(8'h02, 3'd1, 1'b0, 1'b0);
    push(8'h00, 3'd1, 1'b0, 1'b0);
    push(8'h00, 3'd1, 1'b0, 1'b0);
    push(8'h00, 3'd1, 1'b0, 1'b0);
    push(8'h02, 3'd1, 1'b0, 1'b0);
    push(8'h04, 3'd2, 1'b0, 1'b0);
    push(8'h04, 3'd2, 1'b0, 1'b0);
    push(8'h08, 3'd3, 1'b0, 1'b0);
    push(8'h08, 3'd3, 1'b1, 1'b0);
    send(3'd3, 2'b10);
    repeat (3) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    en = 1'b1;
    finish_txn("scan3_freeze");

    // rst during SCAN at idx 2
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h02, 3'd1, 1'b0, 1'b0);
    push(8'h02, 3'd1, 1'b0, 1'b0);
    push(8'h04, 3'd2, 1'b0, 1'b0);
    send(3'd3, 2'b10);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out", 32'(dout), 32'd0);
    chk("midrst_idx_busy", {28'd0, busy, didx}, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; #1;
    chk("midrst_ready_after", 32'(in_ready), 32'd1);

    // Reserved mode 11 code 6: ONEHOT plus err with first output
    push(8'h40, 3'd6, 1'b0, 1'b1);
    push(8'h40, 3'd6, 1'b1, 1'b0);
    send(3'd6, 2'b11);
    finish_txn("rsvd6");

    // SCAN 0 behaves as ONEHOT 0
    push(8'h01, 3'd0, 1'b0, 1'b0);
    push(8'h01, 3'd0, 1'b1, 1'b0);
    send(3'd0, 2'b10);
    finish_txn("scan0");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_decoder_nto2n_seq
